sap_ctrl_seq: RTL and testbench

- Control sequencer for the 8-bit bus CPU. It is the initiator side of the shared tri-state bus: it generates every register's rd_en (bus drive) and wr_en (bus capture) strobe.
- A 6-state ring counter (T1..T6) steps fetch and execute. A decoder turns the IR opcode nibble into a per-T-state control word.
- It sits between the instruction register's opcode output and the rd_en/wr_en/ctrl pins of PC, MAR, RAM, IR, A, B, ALU and OUT.

---
 rtl/sap_ctrl_seq.sv | 115 +++++++++++
 tb/tb_sap_ctrl_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sap_ctrl_seq.sv
// Control sequencer for the 8-bit bus CPU: a T1..T6 ring counter plus HALT,
// decoding the IR opcode into the bus read/write strobes of every register.
module sap_ctrl_seq #(
  parameter int OPW       = 4,
  parameter bit EARLY_END = 1'b0
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  output logic           pc_inc,
  output logic           pc_rd,
  output logic           mar_wr,
  output logic           ram_rd,
  output logic           ir_wr,
  output logic           ir_rd,
  output logic           a_wr,
  output logic           a_rd,
  output logic           b_wr,
  output logic           alu_sub,
  output logic           alu_rd,
  output logic           out_wr,
  output logic [5:0]     tstate,
  output logic           halted
);

  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

  // Control word bit masks, ordered as the output concatenation below.
  localparam logic [11:0] C_PC_INC  = 12'h800;
  localparam logic [11:0] C_PC_RD   = 12'h400;
  localparam logic [11:0] C_MAR_WR  = 12'h200;
  localparam logic [11:0] C_RAM_RD  = 12'h100;
  localparam logic [11:0] C_IR_WR   = 12'h080;
  localparam logic [11:0] C_IR_RD   = 12'h040;
  localparam logic [11:0] C_A_WR    = 12'h020;
  localparam logic [11:0] C_A_RD    = 12'h010;
  localparam logic [11:0] C_B_WR    = 12'h008;
  localparam logic [11:0] C_ALU_SUB = 12'h004;
  localparam logic [11:0] C_ALU_RD  = 12'h002;
  localparam logic [11:0] C_OUT_WR  = 12'h001;

  state_t      state, state_next;
  logic [11:0] ctrl;
  logic        is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= T1;
    else     state <= state_next;
  end

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  // Fetch words ignore the opcode; execute words decode it from T4 onwards.
  always_comb begin
    ctrl       = '0;
    state_next = state;
    case (state)
      T1: begin ctrl = C_PC_RD | C_MAR_WR; state_next = T2; end
      T2: begin ctrl = C_PC_INC;           state_next = T3; end
      T3: begin ctrl = C_RAM_RD | C_IR_WR; state_next = T4; end
      T4: begin
        if (is_lda || is_add || is_sub) ctrl = C_IR_RD | C_MAR_WR;
        else if (is_out)                ctrl = C_A_RD | C_OUT_WR;
        if (is_hlt)                                state_next = HALT;
        else if (EARLY_END && (is_out || is_nop))  state_next = T1;
        else                                       state_next = T5;
      end
      T5: begin
        if (is_lda)               ctrl = C_RAM_RD | C_A_WR;
        else if (is_add || is_sub) ctrl = C_RAM_RD | C_B_WR;
        state_next = (EARLY_END && is_lda) ? T1 : T6;
      end
      T6: begin
        if (is_add)      ctrl = C_ALU_RD | C_A_WR;
        else if (is_sub) ctrl = C_ALU_RD | C_A_WR | C_ALU_SUB;
        state_next = T1;
      end
      HALT:    state_next = HALT;
      default: state_next = T1;
    endcase
    if (!run) state_next = state;
  end

  // clr forces every strobe low even though the state already reads T1.
  assign {pc_inc, pc_rd, mar_wr, ram_rd, ir_wr, ir_rd,
          a_wr, a_rd, b_wr, alu_sub, alu_rd, out_wr} = clr ? 12'h000 : ctrl;

  always_comb begin
    tstate = 6'b000000;
    case (state)
      T1:      tstate = 6'b000001;
      T2:      tstate = 6'b000010;
      T3:      tstate = 6'b000100;
      T4:      tstate = 6'b001000;
      T5:      tstate = 6'b010000;
      T6:      tstate = 6'b100000;
      default: tstate = 6'b000000;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed checks of sap_ctrl_seq, with EARLY_END=0 (dut0) and EARLY_END=1
// (dut1) instances sharing the same inputs.
module tb_sap_ctrl_seq;

  localparam logic [11:0] PC_INC  = 12'h800;
  localparam logic [11:0] PC_RD   = 12'h400;
  localparam logic [11:0] MAR_WR  = 12'h200;
  localparam logic [11:0] RAM_RD  = 12'h100;
  localparam logic [11:0] IR_WR   = 12'h080;
  localparam logic [11:0] IR_RD   = 12'h040;
  localparam logic [11:0] A_WR    = 12'h020;
  localparam logic [11:0] A_RD    = 12'h010;
  localparam logic [11:0] B_WR    = 12'h008;
  localparam logic [11:0] ALU_SUB = 12'h004;
  localparam logic [11:0] ALU_RD  = 12'h002;
  localparam logic [11:0] OUT_WR  = 12'h001;
  localparam logic [11:0] READS   = PC_RD | RAM_RD | IR_RD | A_RD | ALU_RD;
  localparam logic [11:0] NONE    = 12'h000;

  localparam logic [5:0] TS1 = 6'b000001, TS2 = 6'b000010, TS3 = 6'b000100;
  localparam logic [5:0] TS4 = 6'b001000, TS5 = 6'b010000, TS6 = 6'b100000;
  localparam logic [5:0] TSH = 6'b000000;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b1;
  logic [3:0] opcode = 4'b0000;
  wire [11:0] s0, s1;
  wire [5:0]  t0, t1;
  wire        h0, h1;
  int         assertions = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sap_ctrl_seq #(.OPW(4), .EARLY_END(1'b0)) u_dut0 (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode),
    .pc_inc(s0[11]), .pc_rd(s0[10]), .mar_wr(s0[9]), .ram_rd(s0[8]),
    .ir_wr(s0[7]), .ir_rd(s0[6]), .a_wr(s0[5]), .a_rd(s0[4]),
    .b_wr(s0[3]), .alu_sub(s0[2]), .alu_rd(s0[1]), .out_wr(s0[0]),
    .tstate(t0), .halted(h0)
  );

  sap_ctrl_seq #(.OPW(4), .EARLY_END(1'b1)) u_dut1 (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode),
    .pc_inc(s1[11]), .pc_rd(s1[10]), .mar_wr(s1[9]), .ram_rd(s1[8]),
    .ir_wr(s1[7]), .ir_rd(s1[6]), .a_wr(s1[5]), .a_rd(s1[4]),
    .b_wr(s1[3]), .alu_sub(s1[2]), .alu_rd(s1[1]), .out_wr(s1[0]),
    .tstate(t1), .halted(h1)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int which, input logic [11:0] exp_s,
                             input logic [5:0] exp_t, input logic exp_h);
    logic [11:0] s;
    logic [5:0]  t;
    logic        h;
    s = (which == 0) ? s0 : s1;
    t = (which == 0) ? t0 : t1;
    h = (which == 0) ? h0 : h1;
    assertions++;
    assert (s === exp_s) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d strobes observed=%h expected=%h", tag, which, s, exp_s);
    end
    assertions++;
    assert (t === exp_t) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d tstate observed=%b expected=%b", tag, which, t, exp_t);
    end
    assertions++;
    assert (h === exp_h) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d halted observed=%b expected=%b", tag, which, h, exp_h);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [11:0] exp_s,
                           input logic [5:0] exp_t, input logic exp_h);
    checkOutput(tag, 0, exp_s, exp_t, exp_h);
    checkOutput(tag, 1, exp_s, exp_t, exp_h);
  endtask

  task automatic doReset();
    clr = 1'b1;
    applyStimulus(2);
    clr = 1'b0;
    #1;
  endtask

  initial begin
    $display("[TB] sap_ctrl_seq directed test start");

    // Power-on reset, then the first T1 word right after release.
    applyStimulus(3);
    checkBoth("por", NONE, TS1, 1'b0);
    clr = 1'b0;
    #1;
    checkBoth("por_t1", PC_RD | MAR_WR, TS1, 1'b0);

    // LDA: dut0 runs all six T-states, dut1 returns after T5.
    opcode = 4'b0000;
    applyStimulus(1); checkBoth("lda_t2", PC_INC, TS2, 1'b0);
    applyStimulus(1); checkBoth("lda_t3", RAM_RD | IR_WR, TS3, 1'b0);
    applyStimulus(1); checkBoth("lda_t4", IR_RD | MAR_WR, TS4, 1'b0);
    applyStimulus(1); checkBoth("lda_t5", RAM_RD | A_WR, TS5, 1'b0);
    applyStimulus(1);
    checkOutput("lda_t6", 0, NONE, TS6, 1'b0);
    checkOutput("lda_early_t1", 1, PC_RD | MAR_WR, TS1, 1'b0);
    applyStimulus(1);
    checkOutput("lda_wrap_t1", 0, PC_RD | MAR_WR, TS1, 1'b0);

    // SUB: alu_sub only in T6.
    doReset();
    opcode = 4'b0010;
    applyStimulus(3); checkBoth("sub_t4", IR_RD | MAR_WR, TS4, 1'b0);
    applyStimulus(1); checkBoth("sub_t5", RAM_RD | B_WR, TS5, 1'b0);
    applyStimulus(1); checkBoth("sub_t6", ALU_RD | A_WR | ALU_SUB, TS6, 1'b0);
    applyStimulus(1); checkBoth("sub_wrap", PC_RD | MAR_WR, TS1, 1'b0);

    // ADD, with a HLT opcode on the bus during fetch that must be ignored.
    doReset();
    opcode = 4'b1111;
    applyStimulus(1); checkBoth("add_t2", PC_INC, TS2, 1'b0);
    applyStimulus(1); checkBoth("add_t3", RAM_RD | IR_WR, TS3, 1'b0);
    opcode = 4'b0001;
    #1;
    checkBoth("add_t3b", RAM_RD | IR_WR, TS3, 1'b0);
    applyStimulus(1); checkBoth("add_t4", IR_RD | MAR_WR, TS4, 1'b0);
    applyStimulus(1); checkBoth("add_t5", RAM_RD | B_WR, TS5, 1'b0);
    applyStimulus(1); checkBoth("add_t6", ALU_RD | A_WR, TS6, 1'b0);

    // clr mid-T5 of ADD: immediate return to T1 with strobes off.
    doReset();
    applyStimulus(4);
    checkBoth("add_pre_clr_t5", RAM_RD | B_WR, TS5, 1'b0);
    clr = 1'b1;
    #1;
    checkBoth("clr_async", NONE, TS1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkBoth("clr_hold", NONE, TS1, 1'b0);
    end
    clr = 1'b0;
    #1;
    checkBoth("clr_release", PC_RD | MAR_WR, TS1, 1'b0);

    // OUT: dut1 skips T5/T6.
    doReset();
    opcode = 4'b1110;
    applyStimulus(3); checkBoth("out_t4", A_RD | OUT_WR, TS4, 1'b0);
    applyStimulus(1);
    checkOutput("out_t5", 0, NONE, TS5, 1'b0);
    checkOutput("out_early_t1", 1, PC_RD | MAR_WR, TS1, 1'b0);

    // Unknown opcode 0101 behaves as NOP.
    doReset();
    opcode = 4'b0101;
    applyStimulus(3); checkBoth("nop_t4", NONE, TS4, 1'b0);
    applyStimulus(1);
    checkOutput("nop_t5", 0, NONE, TS5, 1'b0);
    checkOutput("nop_early_t1", 1, PC_RD | MAR_WR, TS1, 1'b0);
    applyStimulus(1);
    checkOutput("nop_t6", 0, NONE, TS6, 1'b0);

    // run=0 during T3 holds the state and repeats its strobes.
    doReset();
    opcode = 4'b0000;
    applyStimulus(2);
    checkBoth("hold_enter_t3", RAM_RD | IR_WR, TS3, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkBoth("hold_t3", RAM_RD | IR_WR, TS3, 1'b0);
    end
    run = 1'b1;
    applyStimulus(1);
    checkBoth("hold_release_t4", IR_RD | MAR_WR, TS4, 1'b0);

    // HLT: enters HALT on the edge ending T4 and stays there until clr.
    doReset();
    opcode = 4'b1111;
    applyStimulus(3); checkBoth("hlt_t4", NONE, TS4, 1'b0);
    applyStimulus(1); checkBoth("hlt_entered", NONE, TSH, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      opcode = 4'($urandom);
      applyStimulus(1);
      checkBoth("hlt_stay", NONE, TSH, 1'b1);
    end
    run = 1'b1;
    clr = 1'b1;
    #1;
    checkBoth("hlt_clr", NONE, TS1, 1'b0);
    applyStimulus(1);
    clr = 1'b0;
    #1;
    checkBoth("hlt_clr_release", PC_RD | MAR_WR, TS1, 1'b0);

    // Random run/clr/opcode: at most one bus driver at any time.
    for (int i = 0; i < 10000; i++) begin
      clr    = ($urandom_range(0, 49) == 0);
      run    = ($urandom_range(0, 3) != 0);
      opcode = 4'($urandom);
      #1;
      assertions++;
      assert ($countones(s0 & READS) <= 1) else begin
        failures++;
        $error("[TB] FAIL bus_contention dut0 reads observed=%h expected=at most one bit", s0 & READS);
      end
      assertions++;
      assert ($countones(s1 & READS) <= 1) else begin
        failures++;
        $error("[TB] FAIL bus_contention dut1 reads observed=%h expected=at most one bit", s1 & READS);
      end
      applyStimulus(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
